// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Shares a byte-wide SDRAM controller between two requesters
//               (port 0 video fetch, port 1 CPU/host) and schedules periodic
//               auto-refresh. One access in flight at a time.
//               Optional build macro SDRAM_ARB_RR_EN: round-robin p0/p1
//               arbitration instead of fixed p0 > p1 (refresh always first).
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
  parameter int REFRESH_CYCLES = 960,
  parameter int ADDR_WIDTH     = 23
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [7:0]            p0_wdata,
  output logic                  p0_ack,
  output logic [7:0]            p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [7:0]            p1_wdata,
  output logic                  p1_ack,
  output logic [7:0]            p1_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  mem_refresh,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_din,
  input  logic [7:0]            mem_dout,
  input  logic                  mem_data_ready,
  input  logic                  mem_busy,
  output logic                  refresh_overrun
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_REF, G_P0, G_P1} grant_t;

  state_t                state_q, state_d;
  grant_t                grant_q, grant_d;
  logic                  read_q, read_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  mem_refresh_q, mem_refresh_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_din_q, mem_din_d;
  logic                  p0_ack_q, p0_ack_d;
  logic                  p1_ack_q, p1_ack_d;
  logic [7:0]            p0_rdata_q, p0_rdata_d;
  logic [7:0]            p1_rdata_q, p1_rdata_d;
`ifdef SDRAM_ARB_RR_EN
  // 1 = p1 was granted last, so p0 wins the next tie
  logic                  last_p1_q, last_p1_d;
`endif

  logic wrap;
  logic refresh_taken;
  logic pick_p0;

  // Next-state logic: refresh timer, arbitration and access sequencing
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    read_d        = read_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;
    mem_rd_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_refresh_d = 1'b0;
    p0_ack_d      = 1'b0;
    p1_ack_d      = 1'b0;
    refresh_taken = 1'b0;
`ifdef SDRAM_ARB_RR_EN
    last_p1_d     = last_p1_q;
    pick_p0       = p0_req && (!p1_req || last_p1_q);
`else
    pick_p0       = p0_req;
`endif

    // Free-running timer, independent of the access state machine
    wrap  = (cnt_q == '0);
    cnt_d = wrap ? C_CNT_RELOAD : cnt_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!mem_busy) begin
          if (pending_q) begin
            mem_refresh_d = 1'b1;
            grant_d       = G_REF;
            read_d        = 1'b0;
            refresh_taken = 1'b1;
            state_d       = S_ISSUE;
          end else if (pick_p0) begin
            mem_rd_d   = ~p0_we;
            mem_wr_d   = p0_we;
            mem_addr_d = p0_addr;
            mem_din_d  = p0_wdata;
            grant_d    = G_P0;
            read_d     = ~p0_we;
            state_d    = S_ISSUE;
`ifdef SDRAM_ARB_RR_EN
            last_p1_d  = 1'b0;
`endif
          end else if (p1_req) begin
            mem_rd_d   = ~p1_we;
            mem_wr_d   = p1_we;
            mem_addr_d = p1_addr;
            mem_din_d  = p1_wdata;
            grant_d    = G_P1;
            read_d     = ~p1_we;
            state_d    = S_ISSUE;
`ifdef SDRAM_ARB_RR_EN
            last_p1_d  = 1'b1;
`endif
          end
        end
      end
      // Give the controller one cycle to raise busy
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_data_ready && read_q) begin
          if (grant_q == G_P0) p0_rdata_d = mem_dout;
          if (grant_q == G_P1) p1_rdata_d = mem_dout;
        end
        if (!mem_busy) begin
          p0_ack_d = (grant_q == G_P0);
          p1_ack_d = (grant_q == G_P1);
          state_d  = S_DONE;
        end
      end
      // Ack cycle: requests are ignored so a requester dropping req now is not re-served
      default: state_d = S_IDLE;
    endcase

    // A wrap coinciding with a refresh grant re-arms for the next interval
    pending_d = (pending_q & ~refresh_taken) | wrap;
    overrun_d = overrun_q | (wrap & pending_q & ~refresh_taken);
  end

  // State and registered-output flops with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      grant_q       <= G_REF;
      read_q        <= 1'b0;
      cnt_q         <= C_CNT_RELOAD;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_refresh_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= 8'h00;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      p0_rdata_q    <= 8'h00;
      p1_rdata_q    <= 8'h00;
`ifdef SDRAM_ARB_RR_EN
      last_p1_q     <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      read_q        <= read_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      mem_refresh_q <= mem_refresh_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      p0_ack_q      <= p0_ack_d;
      p1_ack_q      <= p1_ack_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
`ifdef SDRAM_ARB_RR_EN
      last_p1_q     <= last_p1_d;
`endif
    end
  end

  assign mem_rd          = mem_rd_q;
  assign mem_wr          = mem_wr_q;
  assign mem_refresh     = mem_refresh_q;
  assign mem_addr        = mem_addr_q;
  assign mem_din         = mem_din_q;
  assign p0_ack          = p0_ack_q;
  assign p1_ack          = p1_ack_q;
  assign p0_rdata        = p0_rdata_q;
  assign p1_rdata        = p1_rdata_q;
  assign refresh_overrun = overrun_q;

endmodule
`default_nettype wire
